// File: rtl/bp_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : bp_resolve_queue
// Brief    : In-order branch resolution FIFO with predictor update and flush.
// Revision : 1.0
// ============================================================================
module bp_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_fetch_valid,
    input  logic [31:0]              i_fetch_pc,
    input  logic                     i_pred_taken,
    input  logic [31:0]              i_pred_target,
    input  logic                     i_ex_valid,
    input  logic                     i_ex_taken,
    input  logic [31:0]              i_ex_target,
    output logic                     o_update,
    output logic                     o_taken,
    output logic [31:0]              o_pc_ex,
    output logic                     o_mispredict,
    output logic [31:0]              o_redirect_pc,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow,
    output logic [CNT_W-1:0]         o_branch_cnt,
    output logic [CNT_W-1:0]         o_mispred_cnt
);

    localparam int               c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]    c_depth = DEPTH[c_aw:0];

    logic [31:0]       r_pc_mem  [DEPTH];
    logic              r_pt_mem  [DEPTH];
    logic [31:0]       r_tgt_mem [DEPTH];

    logic [c_aw-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]     r_count;
    logic              r_full, r_empty;
    logic              r_update, r_taken, r_mispredict;
    logic [31:0]       r_pc_ex, r_redirect_pc;
    logic              r_overflow, r_underflow;
    logic [CNT_W-1:0]  r_branch_cnt, r_mispred_cnt;

    logic [31:0]       w_head_pc, w_head_tgt, w_redirect;
    logic              w_head_taken;
    logic              w_pop, w_mis, w_pop_ok, w_push, w_wr_en;
    logic [c_aw:0]     w_count_nxt;

    assign w_head_pc    = r_pc_mem[r_rd_ptr];
    assign w_head_taken = r_pt_mem[r_rd_ptr];
    assign w_head_tgt   = r_tgt_mem[r_rd_ptr];

    always_comb begin
        w_pop      = i_ex_valid & ~r_empty;
        w_mis      = w_pop & ((w_head_taken != i_ex_taken) |
                              (i_ex_taken & (w_head_tgt != i_ex_target)));
        w_pop_ok   = w_pop & ~w_mis;
        // A correct pop frees a slot in the same cycle, so a full queue still accepts.
        w_push     = i_fetch_valid & (~r_full | w_pop_ok);
        w_wr_en    = w_push & ~w_mis;
        w_redirect = i_ex_taken ? i_ex_target : (w_head_pc + 32'd4);
        w_count_nxt = r_count;
        if (w_mis) begin
            w_count_nxt = '0;
        end else if (w_wr_en & ~w_pop_ok) begin
            w_count_nxt = r_count + (c_aw+1)'(1);
        end else if (~w_wr_en & w_pop_ok) begin
            w_count_nxt = r_count - (c_aw+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_pc_mem[r_wr_ptr]  <= i_fetch_pc;
            r_pt_mem[r_wr_ptr]  <= i_pred_taken;
            r_tgt_mem[r_wr_ptr] <= i_pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_update      <= 1'b0;
            r_taken       <= 1'b0;
            r_mispredict  <= 1'b0;
            r_pc_ex       <= '0;
            r_redirect_pc <= '0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == c_depth);
            r_empty  <= (w_count_nxt == '0);
            // A flush empties the queue by snapping the read pointer to the write pointer.
            if (w_mis) begin
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_pop_ok) r_rd_ptr <= r_rd_ptr + c_aw'(1);
                if (w_wr_en)  r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            r_update     <= w_pop;
            r_mispredict <= w_mis;
            if (w_pop) begin
                r_taken       <= i_ex_taken;
                r_pc_ex       <= w_head_pc;
                r_redirect_pc <= w_redirect;
                if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mis && r_mispred_cnt != '1) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            if (i_fetch_valid & r_full & ~w_pop_ok) r_overflow  <= 1'b1;
            if (i_ex_valid & r_empty)               r_underflow <= 1'b1;
        end
    end

    assign o_update      = r_update;
    assign o_taken       = r_taken;
    assign o_pc_ex       = r_pc_ex;
    assign o_mispredict  = r_mispredict;
    assign o_redirect_pc = r_redirect_pc;
    assign o_full        = r_full;
    assign o_empty       = r_empty;
    assign o_count       = r_count;
    assign o_overflow    = r_overflow;
    assign o_underflow   = r_underflow;
    assign o_branch_cnt  = r_branch_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bp_resolve_queue.sv
`default_nettype none
// Directed testbench for bp_resolve_queue (DEPTH=4, CNT_W=16).
module tb_bp_resolve_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid, pred_taken, ex_valid, ex_taken;
    logic [31:0] fetch_pc, pred_target, ex_target;
    logic        update, taken, mispredict, full, empty, overflow, underflow;
    logic [31:0] pc_ex, redirect_pc;
    logic [2:0]  count;
    logic [15:0] branch_cnt, mispred_cnt;

    int checks = 0;
    int errors = 0;

    bp_resolve_queue #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_fetch_valid(fetch_valid), .i_fetch_pc(fetch_pc),
        .i_pred_taken(pred_taken), .i_pred_target(pred_target),
        .i_ex_valid(ex_valid), .i_ex_taken(ex_taken), .i_ex_target(ex_target),
        .o_update(update), .o_taken(taken), .o_pc_ex(pc_ex),
        .o_mispredict(mispredict), .o_redirect_pc(redirect_pc),
        .o_full(full), .o_empty(empty), .o_count(count),
        .o_overflow(overflow), .o_underflow(underflow),
        .o_branch_cnt(branch_cnt), .o_mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs applied; returns 1ns after the edge with valids cleared.
    task automatic step(input logic fv, input logic [31:0] fpc, input logic pt,
                        input logic [31:0] ptg, input logic ev, input logic et,
                        input logic [31:0] etg);
        fetch_valid = fv; fetch_pc = fpc; pred_taken = pt; pred_target = ptg;
        ex_valid = ev; ex_taken = et; ex_target = etg;
        @(posedge clk); #1;
        fetch_valid = 1'b0; ex_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        fetch_valid = 1'b0; fetch_pc = '0; pred_taken = 1'b0; pred_target = '0;
        ex_valid = 1'b0; ex_taken = 1'b0; ex_target = '0;
        #12;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_update", 32'(update), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Correctly predicted taken branch
        step(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        chk("a_count", 32'(count), 32'd1);
        chk("a_empty", 32'(empty), 32'd0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
        chk("a_update", 32'(update), 32'd1);
        chk("a_pc_ex", pc_ex, 32'h100);
        chk("a_taken", 32'(taken), 32'd1);
        chk("a_mis", 32'(mispredict), 32'd0);
        chk("a_bcnt", 32'(branch_cnt), 32'd1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("a_idle_update", 32'(update), 32'd0);
        chk("a_hold_pc", pc_ex, 32'h100);
        chk("a_hold_taken", 32'(taken), 32'd1);

        // Direction mispredict: redirect to pc+4
        step(1'b1, 32'h40, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("b_mis", 32'(mispredict), 32'd1);
        chk("b_redirect", redirect_pc, 32'h44);
        chk("b_count", 32'(count), 32'd0);
        chk("b_mcnt", 32'(mispred_cnt), 32'd1);

        // Target mispredict
        step(1'b1, 32'h80, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h304);
        chk("c_mis", 32'(mispredict), 32'd1);
        chk("c_redirect", redirect_pc, 32'h304);
        chk("c_mcnt", 32'(mispred_cnt), 32'd2);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("c_mis_drop", 32'(mispredict), 32'd0);

        // Fill, overflow, simultaneous pop+push at full, drain across wrap
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h1000 + 32'(4*i), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("d_full", 32'(full), 32'd1);
        chk("d_count4", 32'(count), 32'd4);
        chk("d_no_ovf", 32'(overflow), 32'd0);
        step(1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("d_ovf", 32'(overflow), 32'd1);
        chk("d_count_ovf", 32'(count), 32'd4);
        step(1'b1, 32'h1010, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("d_pp_count", 32'(count), 32'd4);
        chk("d_pp_full", 32'(full), 32'd1);
        chk("d_pp_pc", pc_ex, 32'h1000);
        chk("d_pp_mis", 32'(mispredict), 32'd0);
        for (int i = 1; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            chk($sformatf("d_drain%0d", i), pc_ex, 32'h1000 + 32'(4*i));
        end
        chk("d_empty", 32'(empty), 32'd1);
        chk("d_bcnt", 32'(branch_cnt), 32'd8);
        chk("d_ovf_sticky", 32'(overflow), 32'd1);

        // Underflow
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        chk("e_update", 32'(update), 32'd0);
        chk("e_udf", 32'(underflow), 32'd1);
        chk("e_bcnt", 32'(branch_cnt), 32'd8);

        // Mispredicting pop with a same-cycle push flushes everything
        step(1'b1, 32'h600, 1'b1, 32'h700, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h604, 1'b1, 32'h708, 1'b0, 1'b0, 32'h0);
        chk("f_count2", 32'(count), 32'd2);
        step(1'b1, 32'h608, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("f_mis", 32'(mispredict), 32'd1);
        chk("f_redirect", redirect_pc, 32'h604);
        chk("f_count0", 32'(count), 32'd0);
        chk("f_empty", 32'(empty), 32'd1);
        chk("f_mcnt", 32'(mispred_cnt), 32'd3);
        step(1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("f_after_pc", pc_ex, 32'h900);
        chk("f_after_mis", 32'(mispredict), 32'd0);
        chk("f_bcnt", 32'(branch_cnt), 32'd10);

        // Asynchronous reset mid-stream with 3 entries queued
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'hB00 + 32'(4*i), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("g_count3", 32'(count), 32'd3);
        #1 rst = 1'b0;
        #1;
        chk("g_empty", 32'(empty), 32'd1);
        chk("g_count", 32'(count), 32'd0);
        chk("g_full", 32'(full), 32'd0);
        chk("g_pc_ex", pc_ex, 32'h0);
        chk("g_redirect", redirect_pc, 32'h0);
        chk("g_flags", {30'd0, overflow, underflow}, 32'd0);
        chk("g_bcnt", 32'(branch_cnt), 32'd0);
        chk("g_mcnt", 32'(mispred_cnt), 32'd0);
        #1 rst = 1'b1;
        step(1'b1, 32'hA00, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("g_push_count", 32'(count), 32'd1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("g_pop_pc", pc_ex, 32'hA00);
        chk("g_pop_update", 32'(update), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
